// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: FSM states, MEM stage
// control codes, load/store size codes and the size-dependent lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[1] ? 4'b1100 : 4'b0011;
      F3_W:        return 4'b1111;
      default:     return 4'b0001 << lane;
    endcase
  endfunction

  // Stores drive every lane; byte enables pick which ones memory keeps.
  function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_H, F3_HU: return {2{data[15:0]}};
      F3_W:        return data;
      default:     return {4{data[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_ext.sv
// Load lane selection and sign/zero extension of the raw memory word.
module load_ext
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: captures one load/store, drives a held
// request until ready or timeout, then releases the pipeline stall.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [1:0]  MEM_CtrlM,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic [31:0] rdata_m,
  output logic        rdata_valid,
  output logic        fault_m,
  output logic        bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wait;
  logic [29:0] r_waddr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_rdata;
  logic [31:0] w_ext;
  logic        w_access, w_fault, w_capture;

  assign w_access = valid_m && (MEM_CtrlM == MEM_LOAD || MEM_CtrlM == MEM_STORE);
  assign w_fault  = w_access && (!f3_legal(funct3_m) || misaligned(funct3_m, addr_m[1:0]));

  load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_lane   (r_lane),
    .i_word   (dmem_rdata),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    stall_m     = 1'b0;
    dmem_req    = 1'b0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    fault_m     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fault) begin
          fault_m = 1'b1;
        end else if (w_access) begin
          stall_m   = 1'b1;
          w_capture = 1'b1;
          w_next    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        dmem_req = 1'b1;
        stall_m  = 1'b1;
        if (dmem_ready)            w_next = ST_DONE;
        else if (r_wait == TO_LAST) w_next = ST_ERR;
      end
      ST_DONE: begin
        rdata_valid = !r_we;
        w_next      = ST_IDLE;
      end
      ST_ERR: begin
        bus_err = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Inputs may still present an access while reset is held; never stall then.
    if (rst) begin
      stall_m = 1'b0;
      fault_m = 1'b0;
    end
  end

  always_comb begin
    dmem_we    = dmem_req ? r_we : 1'b0;
    dmem_addr  = dmem_req ? {r_waddr, 2'b00} : '0;
    dmem_be    = dmem_req ? r_be : '0;
    dmem_wdata = dmem_req ? r_wdata : '0;
  end

  assign rdata_m = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_waddr  <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_lane   <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_waddr  <= addr_m[31:2];
        r_we     <= (MEM_CtrlM == MEM_STORE);
        r_be     <= byte_en(funct3_m, addr_m[1:0]);
        r_wdata  <= lane_replicate(funct3_m, wdata_m);
        r_funct3 <= funct3_m;
        r_lane   <= addr_m[1:0];
      end
      // Counter sits at zero outside ACCESS, so it is clear on every entry.
      if (r_state == ST_ACCESS) begin
        if (dmem_ready) begin
          if (!r_we) r_rdata <= w_ext;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end else begin
        r_wait <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: randomized MEM-stage traffic, a memory
// responder with chosen wait states, and a monitor checking every response.
module tb_dmem_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m;
  logic [1:0]  MEM_CtrlM;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic [31:0] rdata_m;
  logic        rdata_valid;
  logic        fault_m;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .MEM_CtrlM(MEM_CtrlM),
    .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_m(stall_m), .rdata_m(rdata_m),
    .rdata_valid(rdata_valid), .fault_m(fault_m), .bus_err(bus_err)
  );

  typedef enum int {K_LOAD, K_STORE, K_FAULT, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          req_cyc;
    int          stall_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          wait_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_load = '0;

  function automatic logic [31:0] word_at(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one MEM-stage instruction, record what the controller must do,
  // and hold it until the pipeline is released.
  task automatic issue(input logic v, input logic [1:0] ctrl, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int waits);
    exp_t        e;
    bit          acc, legal, mis;
    int          off, nbytes;
    logic [31:0] word, w;
    acc    = v && (ctrl == 2'b01 || ctrl == 2'b10);
    legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    off    = int'(a[1:0]);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis    = (off % nbytes) != 0;
    valid_m = v; MEM_CtrlM = ctrl; funct3_m = f3; addr_m = a; wdata_m = wd;
    if (acc) begin
      e.addr = a & ~32'h3;
      e.we = (ctrl == 2'b10);
      e.be = '0; e.wdata = '0; e.rdata = '0;
      if (!legal || mis) begin
        e.kind = K_FAULT; e.req_cyc = 0; e.stall_cyc = 0;
      end else begin
        e.be = 4'(((1 << nbytes) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        wait_q.push_back(waits);
        if (waits >= int'(TO)) begin
          e.kind = K_ERR; e.req_cyc = int'(TO); e.stall_cyc = int'(TO) + 1;
        end else begin
          e.req_cyc = waits + 1; e.stall_cyc = waits + 2;
          word = word_at(e.addr);
          if (e.we) begin
            e.kind = K_STORE;
            for (int i = 0; i < 4; i++) if (e.be[i]) word[8*i +: 8] = e.wdata[8*i +: 8];
            mem[e.addr] = word;
          end else begin
            e.kind = K_LOAD;
            w = word >> (8 * off);
            if (nbytes == 1) begin
              w = w & 32'hFF;
              if (!f3[2] && w[7]) w = w | 32'hFFFFFF00;
            end else if (nbytes == 2) begin
              w = w & 32'hFFFF;
              if (!f3[2] && w[15]) w = w | 32'hFFFF0000;
            end
            e.rdata = w;
          end
        end
      end
      exp_q.push_back(e);
    end
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!stall_m) break;
      if (n >= 40) begin
        checks++; errors++;
        $display("FAIL stall_release actual=stuck expected=released");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Memory responder: ready after the chosen number of wait states; random
  // ready pulses while no request is outstanding must be ignored.
  bit rsp_in_req = 1'b0;
  int rsp_cnt = 0;
  int rsp_w = 0;
  initial begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dmem_req) begin
        if (!rsp_in_req) begin
          rsp_in_req = 1'b1;
          rsp_cnt = 0;
          rsp_w = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        dmem_ready = (rsp_cnt == rsp_w);
        dmem_rdata = (rsp_cnt == rsp_w) ? word_at(dmem_addr) : $urandom;
        rsp_cnt++;
      end else begin
        rsp_in_req = 1'b0;
        dmem_ready = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  task automatic take(input kind_t k, input string nm, output bit ok, output exp_t e);
    checks++;
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s actual=event expected=nothing_pending", nm);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        errors++;
        $display("FAIL %s actual_kind=%0d expected_kind=%0d", nm, k, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  int   mon_req_n = 0;
  int   mon_stall_n = 0;
  exp_t mon_e;
  bit   mon_ok;

  task automatic check_counts(input string nm, input exp_t e);
    chk({nm, "_req_cycles"}, mon_req_n, e.req_cyc);
    chk({nm, "_stall_cycles"}, mon_stall_n, e.stall_cyc);
    mon_req_n = 0;
    mon_stall_n = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_req_n = 0;
        mon_stall_n = 0;
        continue;
      end
      if (dmem_req) mon_req_n++;
      if (stall_m) mon_stall_n++;
      if (dmem_req) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=req expected=idle addr=%h", dmem_addr);
        end else begin
          chk("req_addr", dmem_addr, exp_q[0].addr);
          chk("req_we", 32'(dmem_we), 32'(exp_q[0].we));
          chk("req_be", 32'(dmem_be), 32'(exp_q[0].be));
          chk("req_wdata", dmem_wdata, exp_q[0].wdata);
        end
      end
      if (fault_m) begin
        take(K_FAULT, "fault", mon_ok, mon_e);
        if (mon_ok) begin
          chk("fault_stall", 32'(stall_m), 32'd0);
          check_counts("fault", mon_e);
        end
      end
      if (dmem_req && dmem_ready && exp_q.size() > 0 && exp_q[0].kind == K_STORE) begin
        take(K_STORE, "store_done", mon_ok, mon_e);
        if (mon_ok) begin
          chk("store_keeps_rdata", rdata_m, last_load);
          check_counts("store", mon_e);
        end
      end
      if (rdata_valid) begin
        take(K_LOAD, "load_done", mon_ok, mon_e);
        if (mon_ok) begin
          chk("load_rdata", rdata_m, mon_e.rdata);
          last_load = mon_e.rdata;
          check_counts("load", mon_e);
        end
      end
      if (bus_err) begin
        take(K_ERR, "bus_err", mon_ok, mon_e);
        if (mon_ok) begin
          chk("err_stall", 32'(stall_m), 32'd0);
          check_counts("err", mon_e);
        end
      end
    end
  end

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [1:0]  ctrl;
    logic [2:0]  f3;
    int          waits;
    rst = 1'b1; valid_m = 1'b0; MEM_CtrlM = '0; funct3_m = '0; addr_m = '0; wdata_m = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_stall", 32'(stall_m), 32'd0);
    chk("reset_rvalid", 32'(rdata_valid), 32'd0);
    chk("reset_buserr", 32'(bus_err), 32'd0);
    chk("reset_rdata", rdata_m, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    mem[32'h100] = 32'hDEADBEEF;
    issue(1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 0);
    chk("lw_deadbeef", rdata_m, 32'hDEADBEEF);
    mem[32'h100] = 32'h80112233;
    issue(1'b1, 2'b01, 3'b000, 32'h103, 32'h0, 1);
    chk("lb_sign", rdata_m, 32'hFFFFFF80);
    issue(1'b1, 2'b01, 3'b100, 32'h103, 32'h0, 0);
    chk("lbu_zero", rdata_m, 32'h00000080);
    issue(1'b1, 2'b10, 3'b001, 32'h202, 32'h0000ABCD, 3);
    chk("sh_keeps_rdata", rdata_m, 32'h00000080);
    issue(1'b1, 2'b01, 3'b010, 32'h101, 32'h0, 0);
    issue(1'b1, 2'b01, 3'b011, 32'h100, 32'h0, 0);
    issue(1'b1, 2'b10, 3'b001, 32'h203, 32'h1234, 0);
    issue(1'b1, 2'b01, 3'b010, 32'h300, 32'h0, 50);
    issue(1'b1, 2'b10, 3'b010, 32'h304, 32'h55AA55AA, int'(TO));
    issue(1'b1, 2'b01, 3'b101, 32'h202, 32'h0, int'(TO) - 1);
    issue(1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 0);
    issue(1'b1, 2'b11, 3'b011, 32'h101, 32'h0, 0);

    for (int t = 0; t < 300; t++) begin
      ctrl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      waits = ($urandom_range(0, 7) == 0) ? int'(TO) + $urandom_range(0, 2) : $urandom_range(0, 3);
      issue($urandom_range(0, 7) != 0, ctrl, f3, 32'h1000 + $urandom_range(0, 31),
            $urandom, waits);
    end
    drain();

    // Reset while a request is outstanding.
    mon_en = 1'b0;
    wait_q.delete();
    wait_q.push_back(100);
    valid_m = 1'b1; MEM_CtrlM = 2'b01; funct3_m = 3'b010; addr_m = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("stall_during_rst", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid_m = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(dmem_req), 32'd0);
    chk("post_rst_stall", 32'(stall_m), 32'd0);
    chk("post_rst_buserr", 32'(bus_err), 32'd0);
    chk("post_rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("post_rst_rdata", rdata_m, 32'd0);
    @(posedge clk); #1;
    wait_q.delete();
    last_load = '0;
    mon_en = 1'b1;
    issue(1'b1, 2'b01, 3'b001, 32'h402, 32'h0, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
